// File: rtl/fp_mult_datapath_pkg.sv
// Shared types and constants for the byte-entry single-precision multiplier datapath.
// Holds no logic: constants only, plus a pure hex-to-7-segment decode function.
// There is no backpressure; the values here describe formats only.
package fp_pkg;

  localparam int BIAS   = 127;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;

  // Bit positions inside casesspecial = {underflow, NaN, infinity, zero}
  localparam int FLAG_ZERO = 0;
  localparam int FLAG_INF  = 1;
  localparam int FLAG_NAN  = 2;
  localparam int FLAG_UFL  = 3;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } sel_e;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_HA    = 7'b0001000;
  localparam logic [6:0] SEG_HB    = 7'b0000011;
  localparam logic [6:0] SEG_HC    = 7'b1000110;
  localparam logic [6:0] SEG_HD    = 7'b0100001;
  localparam logic [6:0] SEG_HE    = 7'b0000110;
  localparam logic [6:0] SEG_HF    = 7'b0001110;
  localparam logic [6:0] SEG_N     = 7'b0101011;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_I     = 7'b1111001;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_HA;
      4'hB:    seg = SEG_HB;
      4'hC:    seg = SEG_HC;
      4'hD:    seg = SEG_HD;
      4'hE:    seg = SEG_HE;
      default: seg = SEG_HF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/fp_mult_datapath_if.sv
// Board-level byte entry and display bundle of the multiplier datapath.
// Level signals only; the datapath itself does the edge detection.
// No backpressure: inputdata_ready is purely informational for the operator/FSM.
interface fp_mult_datapath_if;
  logic       i_enter;
  logic [7:0] i_inputdata;
  logic       i_loaddata;
  logic       o_inputdata_ready;
  logic [6:0] o_disp3;
  logic [6:0] o_disp2;
  logic [6:0] o_disp1;
  logic [6:0] o_disp0;

  // Board / FSM side: drives buttons and switches, watches displays
  modport master (
    output i_enter, i_inputdata, i_loaddata,
    input  o_inputdata_ready, o_disp3, o_disp2, o_disp1, o_disp0
  );

  // Datapath side
  modport slave (
    input  i_enter, i_inputdata, i_loaddata,
    output o_inputdata_ready, o_disp3, o_disp2, o_disp1, o_disp0
  );
endinterface

// File: rtl/fp_mult_datapath_mul32.sv
// Combinational IEEE-754 single multiply, truncating, denormals flushed to zero.
// Latency: zero cycles (pure combinational).
// No backpressure; outputs follow the operands continuously.
module fp_mul32
  import fp_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_r,
  output logic [3:0]  o_flags
);

  fp32_t       w_a;
  fp32_t       w_b;
  logic        w_sign;
  logic        w_zero_a, w_zero_b, w_inf_a, w_inf_b, w_nan_a, w_nan_b;
  logic [24:0] w_prod_top;   // product bits [47:23]
  logic        w_norm;
  logic [22:0] w_frac;
  logic [9:0]  w_exp;        // two's complement, 10 bits is enough for -125..382

  assign w_a    = i_a;
  assign w_b    = i_b;
  assign w_sign = w_a.sign ^ w_b.sign;

  // Exponent 0 covers both true zero and denormals, which are flushed to zero
  assign w_zero_a = (w_a.exp == '0);
  assign w_zero_b = (w_b.exp == '0);
  assign w_inf_a  = (w_a.exp == '1) && (w_a.frac == '0);
  assign w_inf_b  = (w_b.exp == '1) && (w_b.frac == '0);
  assign w_nan_a  = (w_a.exp == '1) && (w_a.frac != '0);
  assign w_nan_b  = (w_b.exp == '1) && (w_b.frac != '0);

  // Only product bits 47..23 can reach the truncated fraction
  assign w_prod_top = 25'((48'({1'b1, w_a.frac}) * 48'({1'b1, w_b.frac})) >> 23);
  assign w_norm     = w_prod_top[24];
  assign w_frac     = w_norm ? w_prod_top[23:1] : w_prod_top[22:0];
  assign w_exp      = {2'b00, w_a.exp} + {2'b00, w_b.exp} - 10'(BIAS) + {9'd0, w_norm};

  // Special-case priority: NaN, then infinity, then zero, then over/underflow
  always_comb begin
    o_r     = {w_sign, w_exp[7:0], w_frac};
    o_flags = 4'b0000;
    if (w_nan_a || w_nan_b || (w_zero_a && w_inf_b) || (w_inf_a && w_zero_b)) begin
      o_r               = QNAN;
      o_flags[FLAG_NAN] = 1'b1;
    end else if (w_inf_a || w_inf_b) begin
      o_r               = {w_sign, 8'hFF, 23'd0};
      o_flags[FLAG_INF] = 1'b1;
    end else if (w_zero_a || w_zero_b) begin
      o_r                = {w_sign, 31'd0};
      o_flags[FLAG_ZERO] = 1'b1;
    end else if ($signed(w_exp) >= 10'sd255) begin
      o_r               = {w_sign, 8'hFF, 23'd0};
      o_flags[FLAG_INF] = 1'b1;
    end else if ($signed(w_exp) <= 10'sd0) begin
      o_r                = {w_sign, 31'd0};
      o_flags[FLAG_UFL]  = 1'b1;
      o_flags[FLAG_ZERO] = 1'b1;
    end
  end

endmodule

// File: rtl/fp_mult_datapath.sv
// Assembles two float operands from switch bytes, multiplies, drives four 7-seg digits.
// Latency: byte/commit take effect one cycle after the button edge; displays follow operands combinationally.
// No backpressure: a 5th byte is ignored until commit; commit with fewer than 4 bytes is ignored.
module fp_mult_datapath
  import fp_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  fp_mult_datapath_if.slave  bus
);

  logic [31:0] r_word;
  logic [2:0]  r_byte_cnt;
  logic [31:0] r_op_a;
  logic [31:0] r_op_b;
  sel_e        r_sel;
  logic        r_enter_q;
  logic        r_load_q;
  logic        r_ready;

  logic        w_enter_rise;
  logic        w_load_rise;
  logic        w_full;
  logic [31:0] w_data_r;
  logic [3:0]  w_casesspecial;

  assign w_enter_rise = bus.i_enter & ~r_enter_q;
  assign w_load_rise  = bus.i_loaddata & ~r_load_q;
  assign w_full       = (r_byte_cnt == 3'd4);

  // Edge capture, byte shift-in and operand commit; a commit edge swallows a coincident enter edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_word     <= '0;
      r_byte_cnt <= '0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_sel      <= SEL_A;
      r_enter_q  <= 1'b0;
      r_load_q   <= 1'b0;
      r_ready    <= 1'b0;
    end else begin
      r_enter_q <= bus.i_enter;
      r_load_q  <= bus.i_loaddata;
      r_ready   <= w_full;
      if (w_load_rise) begin
        if (w_full) begin
          if (r_sel == SEL_A) begin
            r_op_a <= r_word;
            r_sel  <= SEL_B;
          end else begin
            r_op_b <= r_word;
            r_sel  <= SEL_A;
          end
          r_word     <= '0;
          r_byte_cnt <= '0;
        end
      end else if (w_enter_rise && !w_full) begin
        r_word     <= {r_word[23:0], bus.i_inputdata};
        r_byte_cnt <= r_byte_cnt + 3'd1;
      end
    end
  end

  fp_mul32 u_mul (
    .i_a     (r_op_a),
    .i_b     (r_op_b),
    .o_r     (w_data_r),
    .o_flags (w_casesspecial)
  );

  assign bus.o_inputdata_ready = r_ready;

  // Display: text for NaN/infinity, otherwise the upper half-word in hex
  always_comb begin
    bus.o_disp3 = hex_to_seg(w_data_r[31:28]);
    bus.o_disp2 = hex_to_seg(w_data_r[27:24]);
    bus.o_disp1 = hex_to_seg(w_data_r[23:20]);
    bus.o_disp0 = hex_to_seg(w_data_r[19:16]);
    if (w_casesspecial[FLAG_NAN]) begin
      bus.o_disp3 = SEG_N;
      bus.o_disp2 = SEG_A;
      bus.o_disp1 = SEG_N;
      bus.o_disp0 = SEG_BLANK;
    end else if (w_casesspecial[FLAG_INF]) begin
      bus.o_disp3 = SEG_I;
      bus.o_disp2 = SEG_N;
      bus.o_disp1 = SEG_HF;
      bus.o_disp0 = SEG_BLANK;
    end
  end

endmodule

// File: tb/tb_fp_mult_datapath.sv
// Directed bench for the byte-entry float multiplier datapath.
// Drives buttons on the falling edge and samples outputs there too.
// Operand pairs come from a vector table; entry corner cases are hand sequences.
module tb_fp_mult_datapath;

  // Local glyphs (active-low {g,f,e,d,c,b,a})
  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001;
  localparam logic [6:0] G8 = 7'b0000000;
  localparam logic [6:0] GC = 7'b1000110;
  localparam logic [6:0] GF = 7'b0001110;
  localparam logic [6:0] GN = 7'b0101011;
  localparam logic [6:0] GA = 7'b0001000;
  localparam logic [6:0] GI = 7'b1111001;
  localparam logic [6:0] GB = 7'b1111111;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [3:0]  flags;
    logic [6:0]  d3, d2, d1, d0;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  vec_t vecs[11];

  fp_mult_datapath_if bus_if ();

  fp_mult_datapath dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_disp(input string name, input logic [6:0] e3, input logic [6:0] e2,
                            input logic [6:0] e1, input logic [6:0] e0);
    check({name, ".disp3"}, {25'd0, bus_if.o_disp3}, {25'd0, e3});
    check({name, ".disp2"}, {25'd0, bus_if.o_disp2}, {25'd0, e2});
    check({name, ".disp1"}, {25'd0, bus_if.o_disp1}, {25'd0, e1});
    check({name, ".disp0"}, {25'd0, bus_if.o_disp0}, {25'd0, e0});
  endtask

  // Hold each button for several cycles so a single action per press is exercised
  task automatic press_enter(input logic [7:0] b);
    bus_if.i_inputdata = b;
    bus_if.i_enter     = 1'b1;
    tick(3);
    bus_if.i_enter     = 1'b0;
    tick(2);
  endtask

  task automatic press_load();
    bus_if.i_loaddata = 1'b1;
    tick(3);
    bus_if.i_loaddata = 1'b0;
    tick(2);
  endtask

  task automatic enter_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) press_enter(w[31-8*i -: 8]);
  endtask

  initial begin
    vecs[0]  = '{32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000, G4, G0, GC, G0};
    vecs[1]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b0100, GN, GA, GN, GB};
    vecs[2]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0010, GI, GN, GF, GB};
    vecs[3]  = '{32'h00800000, 32'h00800000, 32'h00000000, 4'b1001, G0, G0, G0, G0};
    vecs[4]  = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000, G4, G0, G1, G0};
    vecs[5]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0000, G3, GF, G8, G0};
    vecs[6]  = '{32'h80000000, 32'h3F800000, 32'h80000000, 4'b0001, G8, G0, G0, G0};
    vecs[7]  = '{32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000, GC, G0, GC, G0};
    vecs[8]  = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b0100, GN, GA, GN, GB};
    vecs[9]  = '{32'h00400000, 32'h40000000, 32'h00000000, 4'b0001, G0, G0, G0, G0};
    vecs[10] = '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0010, GI, GN, GF, GB};

    reset              = 1'b1;
    bus_if.i_enter     = 1'b0;
    bus_if.i_loaddata  = 1'b0;
    bus_if.i_inputdata = 8'h00;
    tick(3);
    reset = 1'b0;
    tick(1);

    // Reset state: 0*0 shows "0000" with the zero flag
    check("rst.ready", {31'd0, bus_if.o_inputdata_ready}, 32'd0);
    check("rst.dataR", dut.w_data_r, 32'h00000000);
    check("rst.flags", {28'd0, dut.w_casesspecial}, 32'h1);
    check_disp("rst", G0, G0, G0, G0);

    // Byte assembly, ready timing and ignored 5th byte
    press_enter(8'h3F);
    press_enter(8'h80);
    press_enter(8'h00);
    check("asm.ready3", {31'd0, bus_if.o_inputdata_ready}, 32'd0);
    press_enter(8'h00);
    check("asm.ready4", {31'd0, bus_if.o_inputdata_ready}, 32'd1);
    press_enter(8'h55);
    check("asm.ready5", {31'd0, bus_if.o_inputdata_ready}, 32'd1);
    press_load();
    check("asm.ready_commit", {31'd0, bus_if.o_inputdata_ready}, 32'd0);
    enter_word(32'h40000000);
    press_load();
    check("one_x_two.dataR", dut.w_data_r, 32'h40000000);
    check("one_x_two.flags", {28'd0, dut.w_casesspecial}, 32'h0);
    check_disp("one_x_two", G4, G0, G0, G0);

    // Operand table: each entry commits A then B
    for (int v = 0; v < 11; v++) begin
      enter_word(vecs[v].a);
      press_load();
      enter_word(vecs[v].b);
      press_load();
      check($sformatf("vec%0d.dataR", v), dut.w_data_r, vecs[v].r);
      check($sformatf("vec%0d.flags", v), {28'd0, dut.w_casesspecial}, {28'd0, vecs[v].flags});
      check_disp($sformatf("vec%0d", v), vecs[v].d3, vecs[v].d2, vecs[v].d1, vecs[v].d0);
    end

    // Commit with only 2 bytes held is ignored; the entry continues afterwards
    press_enter(8'h40);
    press_enter(8'h00);
    press_load();
    check("short.ready", {31'd0, bus_if.o_inputdata_ready}, 32'd0);
    check("short.dataR", dut.w_data_r, vecs[10].r);
    press_enter(8'h00);
    press_enter(8'h00);
    check("short.ready4", {31'd0, bus_if.o_inputdata_ready}, 32'd1);
    press_load();

    // Simultaneous enter+loaddata rise: the byte 0x11 must be dropped
    press_enter(8'h40);
    press_enter(8'h40);
    bus_if.i_inputdata = 8'h11;
    bus_if.i_enter     = 1'b1;
    bus_if.i_loaddata  = 1'b1;
    tick(3);
    bus_if.i_enter     = 1'b0;
    bus_if.i_loaddata  = 1'b0;
    tick(2);
    check("simul.ready", {31'd0, bus_if.o_inputdata_ready}, 32'd0);
    press_enter(8'h00);
    press_enter(8'h00);
    check("simul.ready4", {31'd0, bus_if.o_inputdata_ready}, 32'd1);
    press_load();
    check("simul.dataR", dut.w_data_r, 32'h40C00000);
    check_disp("simul", G4, G0, GC, G0);

    // Reset mid-entry discards partial bytes and both operands
    press_enter(8'h12);
    press_enter(8'h34);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    check("midrst.ready", {31'd0, bus_if.o_inputdata_ready}, 32'd0);
    check("midrst.dataR", dut.w_data_r, 32'h00000000);
    check_disp("midrst", G0, G0, G0, G0);
    enter_word(32'h3F800000);
    press_load();
    check("midrst.a_only.dataR", dut.w_data_r, 32'h00000000);
    check("midrst.a_only.flags", {28'd0, dut.w_casesspecial}, 32'h1);
    check("midrst.a_only.ready", {31'd0, bus_if.o_inputdata_ready}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
